npu_result_reader: RTL and testbench

NPU_RESULT_READER -- requirements
Module: npu_result_reader

---
 rtl/npu_result_reader.sv | 145 ++++++++++++++
 tb/tb_npu_result_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/npu_result_reader.sv
// rtl/npu_result_reader.sv - streams NUM_BYTES result bytes from memory to the host as big-endian 32-bit words
// Optional running byte checksum enabled by defining NPU_READER_CHECKSUM_EN.
module npu_result_reader #(
   parameter int NUM_BYTES = 5408,
   parameter int ADDR_W    = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       control_reg,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [31:0]       readdata,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              done,
   output logic [31:0]       checksum
);
   localparam int             PW       = ADDR_W + 1;
   localparam logic [31:0]    CMD_READ = 32'h4;
   localparam logic [PW-1:0]  TOTAL    = PW'(NUM_BYTES);
   localparam logic [PW-1:0]  WORD     = PW'(4);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;
   state_t state, state_nx;

   logic [PW-1:0] ptr;
   logic [PW-1:0] remain;
   logic [PW-1:0] next_ptr;
   logic [2:0]    phase;
   logic [2:0]    word_len;
   logic          prev_is_cmd;
   logic          armed;
   logic          is_cmd;
   logic          start;
   logic          abort;
   logic          xfer;
   logic          last_word;
   logic          cap_en;
   logic [7:0]    cap_byte;

   // armed blocks a start until control_reg has been seen away from the command after reset
   assign is_cmd    = (control_reg == CMD_READ);
   assign start     = is_cmd && !prev_is_cmd && armed;
   assign abort     = (control_reg == 32'h0);
   assign xfer      = rd_valid && rd_ready;
   assign remain    = TOTAL - ptr;
   assign next_ptr  = ptr + WORD;
   assign last_word = (remain <= WORD);
   assign word_len  = (remain >= WORD) ? 3'd4 : remain[2:0];

   // phase 1..4 captures byte lane phase-1; lanes past the end of the data are zero-filled
   assign cap_en    = (state == FETCH) && !abort && (phase != 3'd0) && (phase <= 3'd4)
                      && ((phase - 3'd1) < word_len);
   assign cap_byte  = cap_en ? mem_rdata : 8'h00;
   assign done      = (state == DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = FETCH;
         FETCH: begin
            if (abort)                  state_nx = IDLE;
            else if (phase == 3'd4)     state_nx = HOLD;
         end
         HOLD: begin
            if (abort)                  state_nx = IDLE;
            else if (xfer)              state_nx = last_word ? DONE : FETCH;
         end
         DONE:  if (!is_cmd) state_nx = IDLE;
         default:                       state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr    <= '0;
         readdata    <= '0;
         rd_valid    <= 1'b0;
         ptr         <= '0;
         phase       <= '0;
         prev_is_cmd <= 1'b0;
         armed       <= 1'b0;
      end else begin
         prev_is_cmd <= is_cmd;
         if (!is_cmd) armed <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  ptr      <= '0;
                  phase    <= '0;
                  mem_addr <= '0;
               end
            end
            FETCH: begin
               if (!abort) begin
                  phase <= phase + 3'd1;
                  if ((phase < 3'd4) && ((phase + 3'd1) < word_len))
                     mem_addr <= mem_addr + ADDR_W'(1);
                  case (phase)
                     3'd1:    readdata[31:24] <= cap_byte;
                     3'd2:    readdata[23:16] <= cap_byte;
                     3'd3:    readdata[15:8]  <= cap_byte;
                     3'd4:    readdata[7:0]   <= cap_byte;
                     default: ;
                  endcase
                  if (phase == 3'd4) rd_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (abort) begin
                  rd_valid <= 1'b0;
               end else if (xfer) begin
                  rd_valid <= 1'b0;
                  ptr      <= next_ptr;
                  if (!last_word) begin
                     mem_addr <= next_ptr[ADDR_W-1:0];
                     phase    <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef NPU_READER_CHECKSUM_EN
   logic [31:0] sum_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                       sum_q <= '0;
      else if ((state == IDLE) && start) sum_q <= '0;
      else if (cap_en)                  sum_q <= sum_q + {24'd0, mem_rdata};
   end

   assign checksum = sum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_npu_result_reader.sv
// tb/tb_npu_result_reader.sv - self-checking bench for npu_result_reader (three sizes, directed and random readouts)
module tb_npu_result_reader;
   localparam int NI = 3;
   localparam int NBS [NI] = '{8, 6, 23};

   logic        clk;
   logic        rst_n;
   logic [31:0] ctrl     [NI];
   logic        ready    [NI];
   logic [7:0]  mem      [NI][32];
   logic [13:0] addr_v   [NI];
   logic [31:0] data_v   [NI];
   logic [31:0] cks_v    [NI];
   logic        valid_v  [NI];
   logic        done_v   [NI];
   int          max_addr [NI];
   int          vectors;
   int          miscompares;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      logic [7:0] rd_l;

      always_ff @(posedge clk) rd_l <= mem[g][addr_v[g][4:0]];

      npu_result_reader #(.NUM_BYTES(NBS[g]), .ADDR_W(14)) u_dut (
         .clk         (clk),
         .reset       (rst_n),
         .control_reg (ctrl[g]),
         .mem_addr    (addr_v[g]),
         .mem_rdata   (rd_l),
         .readdata    (data_v[g]),
         .rd_valid    (valid_v[g]),
         .rd_ready    (ready[g]),
         .done        (done_v[g]),
         .checksum    (cks_v[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < NI; i++)
         if (int'(addr_v[i]) > max_addr[i]) max_addr[i] = int'(addr_v[i]);
   endtask

   function automatic logic [31:0] exp_word(input int i, input int k);
      logic [31:0] w;
      w = '0;
      for (int b = 0; b < 4; b++) begin
         w = w << 8;
         if (4 * k + b < NBS[i]) w[7:0] = mem[i][4 * k + b];
      end
      return w;
   endfunction

   function automatic logic [31:0] exp_sum(input int i);
      logic [31:0] s;
      s = '0;
`ifdef NPU_READER_CHECKSUM_EN
      for (int a = 0; a < NBS[i]; a++) s = s + 32'(mem[i][a]);
`endif
      return s;
   endfunction

   task automatic start(input int i);
      max_addr[i] = 0;
      ctrl[i] = 32'h4;
      tick();
   endtask

   task automatic check_reset_outputs(input int i);
      chk("rst_addr", i, 32'(addr_v[i]), 32'h0);
      chk("rst_data", i, data_v[i], 32'h0);
      chk("rst_valid", i, 32'(valid_v[i]), 32'h0);
      chk("rst_done", i, 32'(done_v[i]), 32'h0);
      chk("rst_cks", i, cks_v[i], 32'h0);
   endtask

   // mode 0: ready high except an optional stall on the first word; mode 1: random ready
   task automatic readout(input int i, input int mode, input int stall_first);
      int nw;
      nw = (NBS[i] + 3) / 4;
      if (mode == 0) ready[i] = 1'b1;
      for (int k = 0; k < nw; k++) begin
         int lat;
         logic [31:0] w;
         lat = 0;
         while (valid_v[i] !== 1'b1 && lat < 20) begin
            if (mode == 1) ready[i] = 1'($urandom_range(0, 1));
            tick();
            lat++;
         end
         chk("latency", i, 32'(lat), 32'd5);
         w = exp_word(i, k);
         chk("word", i, data_v[i], w);
         chk("done_early", i, 32'(done_v[i]), 32'h0);
         if (k == 0 && stall_first > 0) begin
            ready[i] = 1'b0;
            for (int s = 0; s < stall_first; s++) begin
               tick();
               chk("stall_valid", i, 32'(valid_v[i]), 32'h1);
               chk("stall_data", i, data_v[i], w);
            end
            ready[i] = 1'b1;
            tick();
         end else begin
            logic r;
            int tries;
            tries = 0;
            do begin
               r = (mode == 1 && tries < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
               ready[i] = r;
               tick();
               if (!r) begin
                  chk("wait_valid", i, 32'(valid_v[i]), 32'h1);
                  chk("wait_data", i, data_v[i], w);
               end
               tries++;
            end while (!r);
         end
      end
      chk("done", i, 32'(done_v[i]), 32'h1);
      chk("valid_after", i, 32'(valid_v[i]), 32'h0);
      chk("checksum", i, cks_v[i], exp_sum(i));
      chk("max_addr", i, 32'(max_addr[i]), 32'(NBS[i] - 1));
      ready[i] = 1'b0;
   endtask

   task automatic finish_run(input int i);
      ctrl[i] = 32'h0;
      tick();
      chk("done_clear", i, 32'(done_v[i]), 32'h0);
   endtask

   initial begin
      logic [13:0] held;
      int w8;
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         ctrl[i] = 32'h0;
         ready[i] = 1'b0;
         max_addr[i] = 0;
         for (int a = 0; a < 32; a++) mem[i][a] = 8'(a);
      end
      tick();
      tick();
      for (int i = 0; i < NI; i++) check_reset_outputs(i);
      rst_n = 1'b1;
      tick();
      tick();

      // basic readout, ready held high
      start(0);
      readout(0, 0, 0);
      finish_run(0);

      // host stalls the first word for 10 cycles
      start(0);
      readout(0, 0, 10);
      finish_run(0);

      // partial final word
      start(1);
      readout(1, 0, 0);
      finish_run(1);

      // abort during the first fetch, then restart from address 0
      start(0);
      ctrl[0] = 32'h0;
      tick();
      held = addr_v[0];
      for (int c = 0; c < 6; c++) tick();
      chk("abort_valid", 0, 32'(valid_v[0]), 32'h0);
      chk("abort_addr", 0, 32'(addr_v[0]), 32'(held));
      chk("abort_done", 0, 32'(done_v[0]), 32'h0);
      start(0);
      chk("restart_addr", 0, 32'(addr_v[0]), 32'h0);
      readout(0, 0, 0);
      finish_run(0);

      // reset while a word is held, command kept asserted through release
      start(0);
      ready[0] = 1'b0;
      w8 = 0;
      while (valid_v[0] !== 1'b1 && w8 < 20) begin
         tick();
         w8++;
      end
      chk("hold_reached", 0, 32'(valid_v[0]), 32'h1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs(0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) tick();
      chk("norestart_valid", 0, 32'(valid_v[0]), 32'h0);
      chk("norestart_addr", 0, 32'(addr_v[0]), 32'h0);
      ctrl[0] = 32'h0;
      tick();
      start(0);
      readout(0, 0, 0);
      finish_run(0);

      // random memory contents and random host back-pressure
      for (int rep = 0; rep < 4; rep++) begin
         for (int a = 0; a < 32; a++) mem[2][a] = 8'($urandom);
         start(2);
         readout(2, 1, 0);
         finish_run(2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
